// File: rtl/fakeram7_arb_pkg.sv
// Shared types and sizes for the two-port arbiter around the fakeram7_sp_64x32 macro.
package fakeram7_arb_pkg;

  localparam int BITS       = 32;
  localparam int WORD_DEPTH = 64;
  localparam int ADDR_WIDTH = 6;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BITS-1:0]       wdata;
    logic [BITS-1:0]       wmask;
  } arb_req_t;

endpackage

// File: rtl/fakeram7_sp_64x32.sv
// Behavioural model of the fakeram7_sp_64x32 single-port macro: bit-masked write, registered read.
module fakeram7_sp_64x32
  import fakeram7_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  ce_in,
  input  logic                  we_in,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [BITS-1:0]       wd_in,
  input  logic [BITS-1:0]       w_mask_in,
  output logic [BITS-1:0]       rd_out
);

  logic [BITS-1:0] mem [WORD_DEPTH];

  // Contents are never reset; rd_out holds its value on writes and idle cycles.
  always_ff @(posedge clk) begin
    if (ce_in) begin
      if (we_in) begin
        mem[addr_in] <= (wd_in & w_mask_in) | (mem[addr_in] & ~w_mask_in);
      end else begin
        rd_out <= mem[addr_in];
      end
    end
  end

endmodule

// File: rtl/fakeram7_sp_64x32_arbiter.sv
// Round-robin two-port front end for one fakeram7_sp_64x32 macro.
// Define FAKERAM7_ARB_CLEAR_EN to zero the whole macro after every reset before granting.
module fakeram7_sp_64x32_arbiter
  import fakeram7_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [BITS-1:0]       p0_req_wdata,
  input  logic [BITS-1:0]       p0_req_wmask,
  output logic                  p0_rsp_valid,
  output logic [BITS-1:0]       p0_rsp_rdata,
  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [BITS-1:0]       p1_req_wdata,
  input  logic [BITS-1:0]       p1_req_wmask,
  output logic                  p1_rsp_valid,
  output logic [BITS-1:0]       p1_rsp_rdata,
  output logic                  init_done
);

  arb_state_e state;
  arb_req_t   p0_req, p1_req, ram_req;
  logic       run, gnt0, gnt1, ram_ce;
  logic       rr_ptr_q, rr_ptr_d;
  logic       pend_q, pend_d;
  logic       owner_q, owner_d;
  logic [BITS-1:0] ram_rdata;

`ifdef FAKERAM7_ARB_CLEAR_EN
  arb_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clear_cnt_q, clear_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clear_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_cnt_q <= clear_cnt_d;
    end
  end

  // The sweep ends on the edge that writes the last word.
  always_comb begin
    state_d     = state_q;
    clear_cnt_d = clear_cnt_q;
    if (state_q == ST_CLEAR) begin
      clear_cnt_d = clear_cnt_q + ADDR_WIDTH'(1);
      if (clear_cnt_q == ADDR_WIDTH'(WORD_DEPTH - 1)) state_d = ST_RUN;
    end
  end

  assign state = state_q;
`else
  assign state = ST_RUN;
`endif

  assign p0_req = '{we: p0_req_we, addr: p0_req_addr, wdata: p0_req_wdata, wmask: p0_req_wmask};
  assign p1_req = '{we: p1_req_we, addr: p1_req_addr, wdata: p1_req_wdata, wmask: p1_req_wmask};

  assign run  = (state == ST_RUN);
  assign gnt0 = run & p0_req_valid & (~p1_req_valid | ~rr_ptr_q);
  assign gnt1 = run & p1_req_valid & (~p0_req_valid |  rr_ptr_q);

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;
  assign init_done    = run;

  // After a contested grant the pointer moves to the loser.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (run & p0_req_valid & p1_req_valid) rr_ptr_d = gnt0;
  end

  always_comb begin
    ram_ce  = gnt0 | gnt1;
    ram_req = '0;
    if (gnt0)      ram_req = p0_req;
    else if (gnt1) ram_req = p1_req;
`ifdef FAKERAM7_ARB_CLEAR_EN
    if (state == ST_CLEAR) begin
      ram_ce        = 1'b1;
      ram_req.we    = 1'b1;
      ram_req.addr  = clear_cnt_q;
      ram_req.wmask = '1;
    end
`endif
  end

  assign pend_d  = (gnt0 | gnt1) & ~ram_req.we;
  assign owner_d = gnt1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
      pend_q   <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= pend_d;
      owner_q  <= owner_d;
    end
  end

  assign p0_rsp_valid = pend_q & ~owner_q;
  assign p1_rsp_valid = pend_q &  owner_q;
  assign p0_rsp_rdata = ram_rdata;
  assign p1_rsp_rdata = ram_rdata;

  fakeram7_sp_64x32 u_ram (
    .clk       (clk),
    .ce_in     (ram_ce),
    .we_in     (ram_req.we),
    .addr_in   (ram_req.addr),
    .wd_in     (ram_req.wdata),
    .w_mask_in (ram_req.wmask),
    .rd_out    (ram_rdata)
  );

endmodule

// File: tb/tb_fakeram7_sp_64x32_arbiter.sv
// Scoreboard bench for fakeram7_sp_64x32_arbiter; build with FAKERAM7_ARB_CLEAR_EN to cover the clear sweep.
module tb_fakeram7_sp_64x32_arbiter;
  import fakeram7_arb_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
  logic [ADDR_WIDTH-1:0] p0_req_addr;
  logic [BITS-1:0]       p0_req_wdata, p0_req_wmask, p0_rsp_rdata;
  logic                  p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
  logic [ADDR_WIDTH-1:0] p1_req_addr;
  logic [BITS-1:0]       p1_req_wdata, p1_req_wmask, p1_rsp_rdata;
  logic                  init_done;

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fakeram7_sp_64x32_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .p0_req_valid (p0_req_valid),
    .p0_req_ready (p0_req_ready),
    .p0_req_we    (p0_req_we),
    .p0_req_addr  (p0_req_addr),
    .p0_req_wdata (p0_req_wdata),
    .p0_req_wmask (p0_req_wmask),
    .p0_rsp_valid (p0_rsp_valid),
    .p0_rsp_rdata (p0_rsp_rdata),
    .p1_req_valid (p1_req_valid),
    .p1_req_ready (p1_req_ready),
    .p1_req_we    (p1_req_we),
    .p1_req_addr  (p1_req_addr),
    .p1_req_wdata (p1_req_wdata),
    .p1_req_wmask (p1_req_wmask),
    .p1_rsp_valid (p1_rsp_valid),
    .p1_rsp_rdata (p1_rsp_rdata),
    .init_done    (init_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mon_port(input int p, input logic v, input logic [31:0] d);
    exp_t e;
    int   depth;
    depth = (p == 0) ? q0.size() : q1.size();
    if (v) begin
      if (depth == 0) begin
        chk($sformatf("p%0d unexpected rsp_valid", p), 32'(v), 32'd0);
      end else begin
        if (p == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("p%0d rsp_rdata", p), d, e.data);
        chk($sformatf("p%0d rsp latency", p), 32'(cyc), 32'(e.due));
      end
    end else if (depth != 0) begin
      if (p == 0) e = q0[0];
      else        e = q1[0];
      if (e.due <= cyc) begin
        if (p == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        chk($sformatf("p%0d missing rsp_valid", p), 32'(v), 32'd1);
      end
    end
  endtask

  // Response monitor: samples 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    mon_port(0, p0_rsp_valid, p0_rsp_rdata);
    mon_port(1, p1_rsp_valid, p1_rsp_rdata);
  end

  task automatic clear_reqs();
    p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = '0; p0_req_wdata = '0; p0_req_wmask = '0;
    p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = '0; p1_req_wdata = '0; p1_req_wmask = '0;
  endtask

  task automatic set_req(input int p, input logic we, input logic [ADDR_WIDTH-1:0] addr,
                         input logic [31:0] wdata, input logic [31:0] wmask);
    if (p == 0) begin
      p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata; p0_req_wmask = wmask;
    end else begin
      p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata; p1_req_wmask = wmask;
    end
  endtask

  task automatic push_exp(input int p, input logic [31:0] data);
    exp_t e;
    e.due  = cyc + 1;
    e.data = data;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // One uncontested request presented for one cycle; it must be granted at once.
  task automatic single(input string name, input int p, input logic we, input logic [ADDR_WIDTH-1:0] addr,
                        input logic [31:0] wdata, input logic [31:0] wmask, input logic [31:0] exp_rdata);
    @(negedge clk);
    clear_reqs();
    set_req(p, we, addr, wdata, wmask);
    #4;
    chk({name, " ready"}, 32'(p == 0 ? p0_req_ready : p1_req_ready), 32'd1);
    chk({name, " other ready"}, 32'(p == 0 ? p1_req_ready : p0_req_ready), 32'd0);
    if (!we) push_exp(p, exp_rdata);
  endtask

  task automatic idle();
    @(negedge clk);
    clear_reqs();
  endtask

  task automatic wait_init();
    for (int i = 0; i < 200 && !init_done; i++) @(negedge clk);
    chk("init_done before timeout", 32'(init_done), 32'd1);
  endtask

  // Expected winner per cycle under continuous two-port load.
  int win_tbl[6] = '{0, 1, 0, 1, 0, 1};

  initial begin
    int idx0, idx1;
    rst_n = 1'b0;
    clear_reqs();
    repeat (2) @(negedge clk);
    chk("reset p0_rsp_valid", 32'(p0_rsp_valid), 32'd0);
    chk("reset p1_rsp_valid", 32'(p1_rsp_valid), 32'd0);
`ifdef FAKERAM7_ARB_CLEAR_EN
    chk("reset init_done", 32'(init_done), 32'd0);
    rst_n = 1'b1;
    repeat (63) @(posedge clk);
    #1 chk("init_done low after 63 cycles", 32'(init_done), 32'd0);
    @(posedge clk);
    #1 chk("init_done high after 64 cycles", 32'(init_done), 32'd1);
    single("clear read addr5", 0, 1'b0, 6'd5, 32'h0, 32'h0, 32'h0000_0000);
`else
    chk("reset init_done", 32'(init_done), 32'd1);
    rst_n = 1'b1;
`endif

    single("full write", 0, 1'b1, 6'd3, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'h0);
    single("read after write", 1, 1'b0, 6'd3, 32'h0, 32'h0, 32'hDEAD_BEEF);
    single("masked write", 0, 1'b1, 6'd3, 32'h1234_5678, 32'h0000_FFFF, 32'h0);
    single("masked read", 0, 1'b0, 6'd3, 32'h0, 32'h0, 32'hDEAD_5678);

    for (int i = 0; i < 6; i++)
      single($sformatf("prep write %0d", i), 0, 1'b1, 6'(10 + i), 32'hC0DE_0000 + 32'(i), 32'hFFFF_FFFF, 32'h0);

    // Both ports keep a read pending; p0 walks addr 10.., p1 walks addr 13..
    idx0 = 0;
    idx1 = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      clear_reqs();
      set_req(0, 1'b0, 6'(10 + idx0), 32'h0, 32'h0);
      set_req(1, 1'b0, 6'(13 + idx1), 32'h0, 32'h0);
      #4;
      chk($sformatf("rr c%0d p0 ready", c), 32'(p0_req_ready), 32'(win_tbl[c] == 0));
      chk($sformatf("rr c%0d p1 ready", c), 32'(p1_req_ready), 32'(win_tbl[c] == 1));
      if (win_tbl[c] == 0) begin
        push_exp(0, 32'hC0DE_0000 + 32'(idx0));
        idx0++;
      end else begin
        push_exp(1, 32'hC0DE_0003 + 32'(idx1));
        idx1++;
      end
    end
    idle();
    idle();

    // Read granted, then reset lands on the very edge that would raise rsp_valid.
    @(negedge clk);
    clear_reqs();
    set_req(0, 1'b0, 6'd10, 32'h0, 32'h0);
    #4 chk("pre-reset read ready", 32'(p0_req_ready), 32'd1);
    @(posedge clk);
    rst_n = 1'b0;
    clear_reqs();
    #2 chk("rsp dropped by reset", 32'(p0_rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #2 chk("no rsp after reset release", 32'(p0_rsp_valid), 32'd0);
    end
    wait_init();

    idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #4;
      chk("idle ce_in",     32'(dut.u_ram.ce_in),   32'd0);
      chk("idle we_in",     32'(dut.u_ram.we_in),   32'd0);
      chk("idle addr_in",   32'(dut.u_ram.addr_in), 32'd0);
      chk("idle wd_in",     dut.u_ram.wd_in,        32'd0);
      chk("idle w_mask_in", dut.u_ram.w_mask_in,    32'd0);
    end

    repeat (3) @(posedge clk);
    #2;
    chk("p0 scoreboard drained", 32'(q0.size()), 32'd0);
    chk("p1 scoreboard drained", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
